// File: rtl/agc_spi_masters.sv
// Two independent SPI mode-0 masters: a 16-bit write-only display channel with
// active-low chip select, and an 8-bit full-duplex general channel.
module agc_spi_chan #(
  parameter int N           = 8,
  parameter int HALF_PERIOD = 2
) (
  input  logic         raw_clk,
  input  logic         reset,
  input  logic         start,
  input  logic [N-1:0] data_tx,
  input  logic         miso,
  output logic         busy,
  output logic         sclk,
  output logic         mosi,
  output logic [N-1:0] data_rx
);
  localparam int HW = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
  localparam int BW = $clog2(N);

  typedef enum logic [1:0] {IDLE, SHIFT, TAIL} state_t;
  state_t state, state_nxt;

  logic          armed;
  logic [HW-1:0] hcnt;
  logic [BW-1:0] bit_idx;
  logic [N-2:0]  tx_sh;   // MSB goes straight to mosi at acceptance
  logic [N-1:0]  rx_sh;
  logic          half_done, accept;

  assign half_done = (hcnt == HW'(HALF_PERIOD - 1));
  assign accept    = (state == IDLE) && armed && start;
  assign busy      = (state != IDLE);

  always_ff @(posedge raw_clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = SHIFT;
      SHIFT:   if (half_done && sclk && bit_idx == '0) state_nxt = TAIL;
      TAIL:    if (half_done) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge raw_clk) begin
    if (reset) begin
      armed   <= 1'b1;
      hcnt    <= '0;
      bit_idx <= '0;
      tx_sh   <= '0;
      rx_sh   <= '0;
      sclk    <= 1'b0;
      mosi    <= 1'b0;
      data_rx <= '0;
    end else begin
      case (state)
        IDLE: begin
          hcnt <= '0;
          if (!start) armed <= 1'b1;
          if (accept) begin
            armed   <= 1'b0;
            tx_sh   <= data_tx[N-2:0];
            bit_idx <= BW'(N - 1);
            mosi    <= data_tx[N-1];
          end
        end
        SHIFT: begin
          if (half_done) begin
            hcnt <= '0;
            sclk <= ~sclk;
            // Rising edge samples miso; falling edge advances mosi unless last bit
            if (!sclk) rx_sh <= {rx_sh[N-2:0], miso};
            else if (bit_idx != '0) begin
              bit_idx <= bit_idx - 1'b1;
              tx_sh   <= tx_sh << 1;
              mosi    <= tx_sh[N-2];
            end
          end else begin
            hcnt <= hcnt + HW'(1);
          end
        end
        TAIL: begin
          if (half_done) begin
            hcnt    <= '0;
            mosi    <= 1'b0;
            data_rx <= rx_sh;
          end else begin
            hcnt <= hcnt + HW'(1);
          end
        end
        default: ;
      endcase
    end
  end
endmodule

module agc_spi_masters #(
  parameter int HALF_PERIOD = 2
) (
  input  logic        raw_clk,
  input  logic        reset,
  input  logic        disp_start,
  input  logic [15:0] disp_data_tx,
  output logic        disp_busy,
  output logic        disp_cs,
  output logic        disp_sclk,
  output logic        disp_mosi,
  input  logic        spi_start,
  input  logic [7:0]  spi_data_tx,
  output logic [7:0]  spi_data_rx,
  output logic        spi_busy,
  output logic        spi_sclk,
  output logic        spi_mosi,
  input  logic        spi_miso
);
  logic [15:0] disp_rx_unused;

  agc_spi_chan #(.N(16), .HALF_PERIOD(HALF_PERIOD)) u_disp (
    .raw_clk(raw_clk), .reset(reset), .start(disp_start), .data_tx(disp_data_tx),
    .miso(1'b0), .busy(disp_busy), .sclk(disp_sclk), .mosi(disp_mosi),
    .data_rx(disp_rx_unused)
  );

  // Chip select spans the whole busy window, including the tail
  assign disp_cs = ~disp_busy;

  agc_spi_chan #(.N(8), .HALF_PERIOD(HALF_PERIOD)) u_spi (
    .raw_clk(raw_clk), .reset(reset), .start(spi_start), .data_tx(spi_data_tx),
    .miso(spi_miso), .busy(spi_busy), .sclk(spi_sclk), .mosi(spi_mosi),
    .data_rx(spi_data_rx)
  );
endmodule

// File: tb/tb_agc_spi_masters.sv
// Directed bench for agc_spi_masters: timing, bit order, loopback, arming and reset abort.
module tb_agc_spi_masters;
  logic        raw_clk = 1'b0;
  logic        reset;
  logic        disp_start;
  logic [15:0] disp_data_tx;
  logic        disp_busy, disp_cs, disp_sclk, disp_mosi;
  logic        spi_start;
  logic [7:0]  spi_data_tx;
  logic [7:0]  spi_data_rx;
  logic        spi_busy, spi_sclk, spi_mosi, spi_miso;
  logic        loopback;
  logic        miso_drv;

  int n_checks = 0;
  int n_err    = 0;

  assign spi_miso = loopback ? spi_mosi : miso_drv;

  agc_spi_masters #(.HALF_PERIOD(2)) dut (
    .raw_clk(raw_clk), .reset(reset),
    .disp_start(disp_start), .disp_data_tx(disp_data_tx), .disp_busy(disp_busy),
    .disp_cs(disp_cs), .disp_sclk(disp_sclk), .disp_mosi(disp_mosi),
    .spi_start(spi_start), .spi_data_tx(spi_data_tx), .spi_data_rx(spi_data_rx),
    .spi_busy(spi_busy), .spi_sclk(spi_sclk), .spi_mosi(spi_mosi), .spi_miso(spi_miso)
  );

  always #5 raw_clk = ~raw_clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Pulse disp_start for one cycle, then observe the transfer at every falling edge.
  task automatic disp_xfer(input logic [15:0] tx, output int busy_cyc, output int rises,
                           output logic [15:0] bits, output int cs_bad);
    logic prev;
    busy_cyc = 0; rises = 0; bits = '0; cs_bad = 0; prev = 1'b0;
    @(negedge raw_clk);
    disp_data_tx = tx;
    disp_start   = 1'b1;
    @(negedge raw_clk);
    disp_start   = 1'b0;
    disp_data_tx = ~tx;
    for (int i = 0; i < 300; i++) begin
      if (!disp_busy) break;
      busy_cyc++;
      if (disp_cs !== 1'b0) cs_bad++;
      if (disp_sclk && !prev) begin
        rises++;
        bits = {bits[14:0], disp_mosi};
      end
      prev = disp_sclk;
      @(negedge raw_clk);
    end
    if (disp_cs !== 1'b1) cs_bad++;
  endtask

  // Channel S transfer; start is held until busy is seen. miso follows pattern unless loopback.
  task automatic spi_xfer(input logic [7:0] tx, input logic [7:0] pat, input logic [7:0] rx_prev,
                          output int busy_cyc, output int rises, output logic [7:0] bits,
                          output int rx_bad);
    logic prev;
    busy_cyc = 0; rises = 0; bits = '0; rx_bad = 0; prev = 1'b0;
    @(negedge raw_clk);
    spi_data_tx = tx;
    spi_start   = 1'b1;
    miso_drv    = pat[7];
    @(negedge raw_clk);
    for (int i = 0; i < 300; i++) begin
      if (!spi_busy) break;
      spi_start   = 1'b0;
      spi_data_tx = 8'hFF;
      busy_cyc++;
      if (spi_data_rx !== rx_prev) rx_bad++;
      if (spi_sclk && !prev) begin
        rises++;
        bits = {bits[6:0], spi_mosi};
      end
      prev = spi_sclk;
      if (rises < 8) miso_drv = pat[7 - rises];
      @(negedge raw_clk);
    end
    spi_start = 1'b0;
  endtask

  task automatic count_disp_rises(input int cycles, output int n);
    logic prev;
    n = 0;
    prev = disp_busy;
    repeat (cycles) begin
      @(negedge raw_clk);
      if (disp_busy && !prev) n++;
      prev = disp_busy;
    end
  endtask

  initial begin
    int bc, rs, bad, bc2, rs2, bad2, n;
    logic [15:0] dbits;
    logic [7:0]  sbits;

    reset = 1'b1; disp_start = 1'b0; disp_data_tx = '0;
    spi_start = 1'b0; spi_data_tx = '0; loopback = 1'b0; miso_drv = 1'b0;
    repeat (3) @(negedge raw_clk);
    reset = 1'b0;
    repeat (10) @(negedge raw_clk);
    chk("rst_disp_busy", disp_busy, 1'b0);
    chk("rst_spi_busy", spi_busy, 1'b0);
    chk("rst_cs", disp_cs, 1'b1);
    chk("rst_sclk", {disp_sclk, spi_sclk}, 2'b00);
    chk("rst_mosi", {disp_mosi, spi_mosi}, 2'b00);
    chk("rst_rx", spi_data_rx, 8'h00);

    // Channel D, 0xA5C3
    disp_xfer(16'hA5C3, bc, rs, dbits, bad);
    chk("d_busy_cyc", bc, 66);
    chk("d_rises", rs, 16);
    chk("d_bits", dbits, 16'hA5C3);
    chk("d_cs", bad, 0);
    chk("d_mosi_idle", disp_mosi, 1'b0);

    // Channel S loopback
    loopback = 1'b1;
    spi_xfer(8'h3C, 8'h00, 8'h00, bc, rs, sbits, bad);
    loopback = 1'b0;
    chk("s_lb_busy_cyc", bc, 34);
    chk("s_lb_rises", rs, 8);
    chk("s_lb_bits", sbits, 8'h3C);
    chk("s_lb_rx", spi_data_rx, 8'h3C);
    chk("s_lb_rx_hold", bad, 0);

    // Modelled slave returns 0x96, then a zero transfer
    spi_xfer(8'h5A, 8'h96, 8'h3C, bc, rs, sbits, bad);
    chk("s_96_rx", spi_data_rx, 8'h96);
    chk("s_96_bits", sbits, 8'h5A);
    chk("s_96_rx_hold", bad, 0);
    spi_xfer(8'h00, 8'h00, 8'h96, bc, rs, sbits, bad);
    chk("s_00_rx_hold", bad, 0);
    chk("s_00_rx", spi_data_rx, 8'h00);
    chk("s_00_busy_cyc", bc, 34);

    // Held start yields one transfer; a one-cycle drop rearms
    @(negedge raw_clk);
    disp_start = 1'b1;
    count_disp_rises(200, n);
    chk("hold_one_xfer", n, 1);
    disp_start = 1'b0;
    @(negedge raw_clk);
    disp_start = 1'b1;
    count_disp_rises(100, n);
    chk("rearm_xfer", n, 1);
    disp_start = 1'b0;
    @(negedge raw_clk);
    chk("rearm_idle", disp_busy, 1'b0);

    // Pulse while busy is ignored
    disp_start = 1'b1;
    @(negedge raw_clk);
    disp_start = 1'b0;
    repeat (20) @(negedge raw_clk);
    disp_start = 1'b1;
    @(negedge raw_clk);
    disp_start = 1'b0;
    count_disp_rises(120, n);
    chk("busy_pulse_ignored", n, 0);
    chk("busy_pulse_idle", disp_busy, 1'b0);

    // Reset during bit 5 of a channel D transfer
    @(negedge raw_clk);
    disp_data_tx = 16'hFFFF;
    disp_start = 1'b1;
    @(negedge raw_clk);
    disp_start = 1'b0;
    rs = 0;
    begin
      logic prev;
      prev = 1'b0;
      for (int i = 0; i < 200 && rs < 11; i++) begin
        if (disp_sclk && !prev) rs++;
        prev = disp_sclk;
        @(negedge raw_clk);
      end
    end
    chk("abort_reached_bit5", rs, 11);
    reset = 1'b1;
    @(negedge raw_clk);
    chk("abort_busy", disp_busy, 1'b0);
    chk("abort_cs", disp_cs, 1'b1);
    chk("abort_sclk", disp_sclk, 1'b0);
    chk("abort_mosi", disp_mosi, 1'b0);
    chk("abort_rx", spi_data_rx, 8'h00);
    reset = 1'b0;
    @(negedge raw_clk);
    disp_xfer(16'h1234, bc, rs, dbits, bad);
    chk("post_abort_busy_cyc", bc, 66);
    chk("post_abort_bits", dbits, 16'h1234);
    chk("post_abort_cs", bad, 0);

    // Both channels concurrently
    fork
      disp_xfer(16'h5A0F, bc, rs, dbits, bad);
      spi_xfer(8'hC3, 8'h69, 8'h00, bc2, rs2, sbits, bad2);
    join
    chk("conc_d_busy_cyc", bc, 66);
    chk("conc_d_bits", dbits, 16'h5A0F);
    chk("conc_d_cs", bad, 0);
    chk("conc_s_busy_cyc", bc2, 34);
    chk("conc_s_bits", sbits, 8'hC3);
    chk("conc_s_rx", spi_data_rx, 8'h69);
    chk("conc_s_rx_hold", bad2, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
